// File: rtl/rand_pkg.sv
// Shared constants, FSM state type and LFSR stepping helper for the random byte sources.
package rand_pkg;

    localparam int LFSR_W = 16;
    localparam int OUT_W  = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEED = 2'd2
    } rand_state_t;

    // n single Fibonacci steps, shifting left with the feedback bit entering at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step_n(input logic [LFSR_W-1:0] s,
                                                       input int unsigned n);
        logic [LFSR_W-1:0] v;
        logic              fb;
        v = s;
        for (int unsigned i = 0; i < n; i++) begin
            fb = v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
            v  = {v[LFSR_W-2:0], fb};
        end
        return v;
    endfunction

endpackage

// File: rtl/rand_byte_source_if.sv
// Valid/ready byte stream from a random source to its consumer.
interface rand_byte_source_if #(parameter int OUT_W = 8);
    logic             rnd_valid;
    logic             rnd_ready;
    logic [OUT_W-1:0] rnd_data;

    modport master (output rnd_valid, output rnd_data, input rnd_ready);
    modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/rand_fifo.sv
// Small FIFO with a registered head, separate level counter and synchronous flush.
module rand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_head,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = {{(LW-1){1'b0}}, 1'b1};

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_head;

    logic          w_pop;
    logic          w_push;
    logic [PW-1:0] w_rd_nxt;

    assign w_pop    = i_pop & (r_level != {LW{1'b0}});
    assign w_push   = i_push & ((r_level != FULL_LVL) | w_pop);
    assign w_rd_nxt = r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};

    // Storage array, pointers, level and registered head byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_head   <= {W{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_head   <= {W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    r_level <= r_level + ONE_LVL;
                    if (r_level == {LW{1'b0}}) begin
                        r_head <= i_data;
                    end
                end
                2'b01: begin
                    r_level <= r_level - ONE_LVL;
                    if (r_level != ONE_LVL) begin
                        r_head <= r_mem[w_rd_nxt];
                    end
                end
                2'b11: begin
                    // Level unchanged; with a single entry the new byte becomes the head.
                    if (r_level == ONE_LVL) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_mem[w_rd_nxt];
                    end
                end
                default: begin
                    r_level <= r_level;
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_level = r_level;
    assign o_valid = (r_level != {LW{1'b0}});
    assign o_full  = (r_level == FULL_LVL);

endmodule

// File: rtl/rand_byte_source.sv
// LFSR random byte generator feeding a FIFO, with runtime reseed and valid/ready output.
module rand_byte_source
    import rand_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed,
    rand_byte_source_if.master       rnd_if,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [LFSR_W-1:0]        lfsr_state
);
    rand_state_t       r_state;
    rand_state_t       w_next;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_valid;
    logic [OUT_W-1:0]  w_head;

    // A zero state would lock the LFSR, so it is replaced by the default seed.
    assign w_lfsr_next = (r_lfsr == {LFSR_W{1'b0}}) ? DEFAULT_SEED
                                                    : lfsr_step_n(r_lfsr, OUT_W);

    // Reseeding wins over both handshake sides; a pending pop is simply not taken.
    assign w_pop  = w_valid & rnd_if.rnd_ready & ~seed_load;
    assign w_push = (r_state == RUN) & enable & ~seed_load & (~w_full | w_pop);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: reseed from anywhere, otherwise follow enable.
    always_comb begin
        w_next = r_state;
        if (seed_load) begin
            w_next = SEED;
        end else begin
            case (r_state)
                IDLE:    w_next = enable ? RUN : IDLE;
                RUN:     w_next = enable ? RUN : IDLE;
                SEED:    w_next = enable ? RUN : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // LFSR register: load seed, advance one byte per push, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= DEFAULT_SEED;
        end else if (seed_load) begin
            r_lfsr <= (seed == {LFSR_W{1'b0}}) ? DEFAULT_SEED : seed;
        end else if (w_push) begin
            r_lfsr <= w_lfsr_next;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    rand_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (seed_load),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_lfsr_next[OUT_W-1:0]),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign rnd_if.rnd_valid = w_valid;
    assign rnd_if.rnd_data  = w_head;
    assign lfsr_state       = r_lfsr;

endmodule

// File: tb/tb_rand_byte_source.sv
// Directed bench for rand_byte_source with a queue-based reference model.
module tb_rand_byte_source;

    localparam logic [15:0] DEF = 16'hACE1;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_SEED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [2:0]  fifo_level;
    logic [15:0] lfsr_state;

    rand_byte_source_if #(.OUT_W(8)) bus ();

    rand_byte_source #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed       (seed),
        .rnd_if     (bus.master),
        .fifo_level (fifo_level),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mq[$];
    logic [15:0] mlf;
    int          mph;
    logic [7:0]  acc[$];

    function automatic logic [15:0] gen_byte_state(input logic [15:0] s);
        logic [15:0] v;
        logic        fb;
        if (s == 16'h0000) return DEF;
        v = s;
        for (int i = 0; i < 8; i++) begin
            fb = v[15] ^ v[13] ^ v[12] ^ v[10];
            v  = {v[14:0], fb};
        end
        return v;
    endfunction

    function automatic logic [31:0] acc_at(input int idx);
        if (idx < acc.size()) return {24'h0, acc[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mlf = DEF;
        mph = PH_IDLE;
    endtask

    task automatic model_update();
        bit pop_m;
        bit push_m;
        if (seed_load) begin
            mlf = (seed == 16'h0000) ? DEF : seed;
            mq.delete();
            mph = PH_SEED;
        end else begin
            pop_m  = (mq.size() != 0) && bus.rnd_ready;
            push_m = (mph == PH_RUN) && enable && ((mq.size() < 4) || pop_m);
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                mlf = gen_byte_state(mlf);
                mq.push_back(mlf[7:0]);
            end
            mph = enable ? PH_RUN : PH_IDLE;
        end
    endtask

    task automatic compare();
        chk("valid", 32'(bus.rnd_valid), 32'(mq.size() != 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("lfsr", 32'(lfsr_state), 32'(mlf));
        if (mq.size() != 0) chk("data", 32'(bus.rnd_data), 32'(mq[0]));
    endtask

    task automatic step();
        if (rst_n && !seed_load && bus.rnd_valid && bus.rnd_ready) acc.push_back(bus.rnd_data);
        if (!rst_n) model_reset();
        else model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        int n0, n1, n2, n3;
        bus.rnd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_valid", 32'(bus.rnd_valid), 32'd0);
        chk("rst_data", 32'(bus.rnd_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_lfsr", 32'(lfsr_state), 32'hACE1);
        rst_n = 1'b1;

        // First bytes after reset, consumer always ready.
        enable = 1'b1;
        bus.rnd_ready = 1'b1;
        step();
        chk("first_valid_late", 32'(bus.rnd_valid), 32'd0);
        step();
        step();
        chk("lfsr_e455", 32'(lfsr_state), 32'hE455);
        chk("byte0_e4", acc_at(0), 32'hE4);
        repeat (4) step();
        chk("byte1_55", acc_at(1), 32'h55);

        // Stalled consumer: FIFO fills and holds.
        bus.rnd_ready = 1'b0;
        repeat (8) step();
        chk("full_level", 32'(fifo_level), 32'd4);
        bus.rnd_ready = 1'b1;
        repeat (8) step();

        // Zero seed behaves as the default seed.
        seed = 16'h0000;
        seed_load = 1'b1;
        n0 = acc.size();
        step();
        seed_load = 1'b0;
        step();
        chk("seed_cycle_valid", 32'(bus.rnd_valid), 32'd0);
        repeat (4) step();
        chk("zero_seed_e4", acc_at(n0), 32'hE4);

        // Reseed while full with ready high: pop discarded, flush.
        bus.rnd_ready = 1'b0;
        repeat (6) step();
        chk("pre_seed_full", 32'(fifo_level), 32'd4);
        seed = 16'h1234;
        seed_load = 1'b1;
        bus.rnd_ready = 1'b1;
        n1 = acc.size();
        step();
        seed_load = 1'b0;
        chk("flush_level", 32'(fifo_level), 32'd0);
        repeat (4) step();
        chk("seed1234_8d", acc_at(n1), 32'h8D);

        // Disable with 3 buffered: drain, then resume.
        bus.rnd_ready = 1'b0;
        for (int i = 0; i < 10 && mq.size() < 3; i++) step();
        chk("buffered3", 32'(fifo_level), 32'd3);
        enable = 1'b0;
        step();
        bus.rnd_ready = 1'b1;
        n2 = acc.size();
        repeat (5) step();
        chk("drained3", 32'(acc.size() - n2), 32'd3);
        chk("drained_valid", 32'(bus.rnd_valid), 32'd0);
        enable = 1'b1;
        repeat (6) step();

        // Asynchronous reset mid-stream.
        bus.rnd_ready = 1'b0;
        repeat (2) step();
        chk("pre_rst_valid", 32'(bus.rnd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.rnd_valid), 32'd0);
        chk("arst_data", 32'(bus.rnd_data), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_lfsr", 32'(lfsr_state), 32'hACE1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rnd_ready = 1'b1;
        n3 = acc.size();
        repeat (5) step();
        chk("restart_e4", acc_at(n3), 32'hE4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
